pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MangoMIPS32 core: IF, ID, EX, MEM, WB.
- Merges per-stage stall requests and MEM-stage exception/ERET events.
- Drives hold (stall), bubble (clear) and flush controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC redirect.
- Sequences exception redirects that arrive while an instruction fetch is still outstanding, so the bus transaction drains before the PC is redirected.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl_stall_resolve.sv | 33 +++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, bus widths,
// FSM encodings and the BEV=1 general exception vector.
package pipe_ctrl_pkg;

  localparam int STG_W = 5;

  // Index of each hold/clear bit, named after the stage the register feeds.
  localparam int STG_PC  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int          ADDR_W_DEF  = 32;
  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages (master) and the sequencer (slave).
// Requests flow in combinationally; stall/bubble/flush/redirect flow back the same cycle.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  import pipe_ctrl_pkg::*;

  logic              stallreq_if;
  logic              if_busy;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              mem_exc;
  logic              mem_eret;
  logic [ADDR_W-1:0] cp0_epc;

  logic [STG_W-1:0]  stall;
  logic [STG_W-1:0]  bubble;
  logic              flush;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;

  modport master (
    output stallreq_if, if_busy, stallreq_id, stallreq_ex, stallreq_mem,
           mem_exc, mem_eret, cp0_epc,
    input  stall, bubble, flush, redirect, redirect_pc, busy
  );

  modport slave (
    input  stallreq_if, if_busy, stallreq_id, stallreq_ex, stallreq_mem,
           mem_exc, mem_eret, cp0_epc,
    output stall, bubble, flush, redirect, redirect_pc, busy
  );

endinterface

// File: rtl/pipe_ctrl_stall_resolve.sv
// Priority encoder: oldest stalling stage holds itself and everything younger,
// and inserts a bubble into the register just downstream of it. Purely combinational.
module pipe_ctrl_stall_resolve
  import pipe_ctrl_pkg::*;
(
  input  logic             i_req_if,
  input  logic             i_req_id,
  input  logic             i_req_ex,
  input  logic             i_req_mem,
  output logic [STG_W-1:0] o_stall,
  output logic [STG_W-1:0] o_bubble
);

  always_comb begin
    o_stall  = '0;
    o_bubble = '0;
    if (i_req_mem) begin
      o_stall[STG_MEM:STG_PC] = '1;
      o_bubble[STG_WB]        = 1'b1;
    end else if (i_req_ex) begin
      o_stall[STG_EX:STG_PC]  = '1;
      o_bubble[STG_MEM]       = 1'b1;
    end else if (i_req_id) begin
      o_stall[STG_ID:STG_PC]  = '1;
      o_bubble[STG_EX]        = 1'b1;
    end else if (i_req_if) begin
      // The IF/ID bubble is the clrslot that discards the half-fetched slot.
      o_stall[STG_PC]         = 1'b1;
      o_bubble[STG_ID]        = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests and MEM exception/ERET events into hold/clear/flush/redirect.
// Controls are combinational from state and inputs; a redirect behind a live fetch waits in DRAIN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   pif
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_pc;

  logic              w_event;
  logic [ADDR_W-1:0] w_target;
  logic [STG_W-1:0]  w_res_stall;
  logic [STG_W-1:0]  w_res_bubble;
  logic [STG_W-1:0]  w_stall;
  logic [STG_W-1:0]  w_bubble;
  logic              w_flush;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_busy;

  assign w_event  = pif.mem_exc | pif.mem_eret;
  assign w_target = pif.mem_exc ? EXC_VEC : pif.cp0_epc;

  pipe_ctrl_stall_resolve u_resolve (
    .i_req_if  (pif.stallreq_if),
    .i_req_id  (pif.stallreq_id),
    .i_req_ex  (pif.stallreq_ex),
    .i_req_mem (pif.stallreq_mem),
    .o_stall   (w_res_stall),
    .o_bubble  (w_res_bubble)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_event) begin
            r_pend_pc <= w_target;
            if (pif.if_busy) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pif.if_busy) r_state <= ST_REDIR;
        end
        ST_REDIR: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_stall       = '0;
    w_bubble      = '0;
    w_flush       = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_busy        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_event) begin
          // Events override every stall request; redirect only if no fetch is in flight.
          w_flush = 1'b1;
          if (!pif.if_busy) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_target;
          end
        end else begin
          w_stall  = w_res_stall;
          w_bubble = w_res_bubble;
        end
      end
      ST_DRAIN: begin
        w_stall[STG_PC] = 1'b1;
        w_flush         = 1'b1;
        w_busy          = 1'b1;
      end
      ST_REDIR: begin
        w_redirect    = 1'b1;
        w_redirect_pc = r_pend_pc;
        w_flush       = 1'b1;
        w_busy        = 1'b1;
      end
      default: ;
    endcase
  end

  // Controls are forced quiet while reset is held, independent of the request inputs.
  assign pif.stall       = rst ? w_stall       : '0;
  assign pif.bubble      = rst ? w_bubble      : '0;
  assign pif.flush       = rst & w_flush;
  assign pif.redirect    = rst & w_redirect;
  assign pif.redirect_pc = rst ? w_redirect_pc : '0;
  assign pif.busy        = rst & w_busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: each task drives a per-cycle stimulus table and
// scores the controls against expectations queued as the stimulus is applied.
module tb_pipe_ctrl;

  typedef struct packed {
    logic rstn;
    logic sif;
    logic ifb;
    logic sid;
    logic sex;
    logic smem;
    logic exc;
    logic eret;
  } in_t;

  typedef struct packed {
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic        flush;
    logic        redirect;
    logic [31:0] pc;
    logic        busy;
  } obs_t;

  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam logic [31:0] EPC = 32'h80001234;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  pipe_ctrl_if #(.ADDR_W(32)) pif ();

  pipe_ctrl #(.ADDR_W(32), .EXC_VEC(EXC)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(bit rstn, bit sif, bit ifb, bit sid, bit sex, bit smem, bit exc, bit eret);
    in_t v;
    v = {rstn, sif, ifb, sid, sex, smem, exc, eret};
    return v;
  endfunction

  function automatic obs_t mo(logic [4:0] st, logic [4:0] bu, bit fl, bit rd, logic [31:0] pc, bit bz);
    obs_t v;
    v = {st, bu, fl, rd, pc, bz};
    return v;
  endfunction

  function automatic obs_t observe();
    obs_t v;
    v = {pif.stall, pif.bubble, pif.flush, pif.redirect, pif.redirect_pc, pif.busy};
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst              = v.rstn;
    pif.stallreq_if  = v.sif;
    pif.if_busy      = v.ifb;
    pif.stallreq_id  = v.sid;
    pif.stallreq_ex  = v.sex;
    pif.stallreq_mem = v.smem;
    pif.mem_exc      = v.exc;
    pif.mem_eret     = v.eret;
  endtask

  task automatic test_reset();
    in_t  ins[2];
    obs_t exps[2];
    obs_t got, exp;
    ins[0] = mi(0, 1, 1, 1, 1, 1, 1, 0); exps[0] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    ins[1] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[1] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(ins[i]);
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_multi_req();
    in_t  ins[4];
    obs_t exps[4];
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      ins[i] = mi(1, 0, 0, 1, 0, 1, 0, 0); exps[i] = mo(5'b01111, 5'b10000, 0, 0, 32'h0, 0);
    end
    ins[3] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[3] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ins[i]);
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL multi_req[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_if_clrslot();
    in_t  ins[4];
    obs_t exps[4];
    obs_t got, exp;
    ins[0] = mi(1, 1, 0, 0, 0, 0, 0, 0); exps[0] = mo(5'b00001, 5'b00010, 0, 0, 32'h0, 0);
    ins[1] = mi(1, 1, 0, 0, 1, 0, 0, 0); exps[1] = mo(5'b00111, 5'b01000, 0, 0, 32'h0, 0);
    ins[2] = mi(1, 1, 1, 1, 0, 0, 0, 0); exps[2] = mo(5'b00011, 5'b00100, 0, 0, 32'h0, 0);
    ins[3] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[3] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ins[i]);
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL if_clrslot[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_exc_direct();
    in_t  ins[4];
    obs_t exps[4];
    obs_t got, exp;
    pif.cp0_epc = EPC;
    ins[0] = mi(1, 0, 0, 0, 1, 0, 1, 0); exps[0] = mo(5'b00000, 5'b00000, 1, 1, EXC, 0);
    ins[1] = mi(1, 0, 0, 0, 1, 0, 0, 0); exps[1] = mo(5'b00111, 5'b01000, 0, 0, 32'h0, 0);
    ins[2] = mi(1, 0, 0, 0, 0, 1, 1, 1); exps[2] = mo(5'b00000, 5'b00000, 1, 1, EXC, 0);
    ins[3] = mi(1, 1, 0, 0, 0, 0, 0, 1); exps[3] = mo(5'b00000, 5'b00000, 1, 1, EPC, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ins[i]);
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL exc_direct[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_eret_drain();
    in_t  ins[7];
    obs_t exps[7];
    obs_t got, exp;
    // Event cycle, then four DRAIN cycles (last sees if_busy low), REDIR, RUN.
    ins[0] = mi(1, 0, 1, 0, 0, 1, 0, 1); exps[0] = mo(5'b00000, 5'b00000, 1, 0, 32'h0, 0);
    ins[1] = mi(1, 0, 1, 0, 0, 0, 1, 0); exps[1] = mo(5'b00001, 5'b00000, 1, 0, 32'h0, 1);
    ins[2] = mi(1, 0, 1, 0, 1, 0, 0, 0); exps[2] = mo(5'b00001, 5'b00000, 1, 0, 32'h0, 1);
    ins[3] = mi(1, 0, 1, 1, 0, 0, 0, 1); exps[3] = mo(5'b00001, 5'b00000, 1, 0, 32'h0, 1);
    ins[4] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[4] = mo(5'b00001, 5'b00000, 1, 0, 32'h0, 1);
    ins[5] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[5] = mo(5'b00000, 5'b00000, 1, 1, EPC, 1);
    ins[6] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[6] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(ins[i]);
      pif.cp0_epc = (i == 0) ? EPC : 32'hDEAD0000;
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL eret_drain[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    in_t  ins[6];
    obs_t exps[6];
    obs_t got, exp;
    ins[0] = mi(1, 0, 1, 0, 0, 0, 1, 0); exps[0] = mo(5'b00000, 5'b00000, 1, 0, 32'h0, 0);
    ins[1] = mi(1, 0, 1, 0, 0, 0, 0, 0); exps[1] = mo(5'b00001, 5'b00000, 1, 0, 32'h0, 1);
    ins[2] = mi(0, 0, 1, 0, 0, 0, 0, 0); exps[2] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    ins[3] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[3] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    ins[4] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[4] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    ins[5] = mi(1, 0, 0, 0, 0, 0, 0, 0); exps[5] = mo(5'b00000, 5'b00000, 0, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(ins[i]);
      sb.push_back(exps[i]);
      #1;
      got = observe();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_in_drain[%0d] got %h exp %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(mi(1, 0, 0, 0, 0, 0, 0, 0));
    pif.cp0_epc = '0;
    #1 rst = 1'b0;
    test_reset();
    test_multi_req();
    test_if_clrslot();
    test_exc_direct();
    test_eret_drain();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
